// File: rtl/chunked_subtractor.sv
// chunked_subtractor
//    Multi-cycle N-bit subtractor: d = a - b computed as a + ~b + 1, K bits
//    per clock, with the inter-chunk carry held in a register.
//
// Parameters
//    N        operand/result width (must be a multiple of K)
//    K        chunk width processed per clock (1 <= K <= N)
//
// Ports
//    clk      rising-edge clock
//    reset    asynchronous active-high reset
//    start    request an operation; honoured only in IDLE or DONE
//    a, b     minuend / subtrahend, captured on the accepting edge
//    busy     high while chunks are being processed
//    done     one-cycle pulse when d/borrow/overflow have just been updated
//    d        (a - b) mod 2^N
//    borrow   1 iff a < b unsigned
//    overflow signed overflow of the subtraction
module chunked_subtractor #(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] d,
   output logic         borrow,
   output logic         overflow
);

   localparam int NC = N / K;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_sh_q, a_sh_d;
   logic [N-1:0]   bn_sh_q, bn_sh_d;
   logic [N-1:0]   res_q, res_d;
   logic [N-1:0]   d_q, d_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic           borrow_q, borrow_d;
   logic           ovf_q, ovf_d;

   logic [K:0]     chunk_sum;
   logic [N-1:0]   res_shifted;
   logic           last_chunk;

   // K+1-bit chunk add: zero-extended operands plus the held carry.
   assign chunk_sum = {1'b0, a_sh_q[K-1:0]} + {1'b0, bn_sh_q[K-1:0]}
                    + {{K{1'b0}}, carry_q};

   // Result is assembled LSB-chunk first, each new chunk entering at the top;
   // after NC shifts the first chunk has reached bit 0.
   generate
      if (N == K) begin : g_single_chunk
         assign res_shifted = chunk_sum[K-1:0];
      end else begin : g_multi_chunk
         assign res_shifted = {chunk_sum[K-1:0], res_q[N-1:K]};
      end
   endgenerate

   assign last_chunk = (cnt_q == CW'(NC - 1));

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      bn_sh_d  = bn_sh_q;
      res_d    = res_q;
      d_d      = d_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               // Subtract as a + ~b + 1: invert b once here, seed carry with 1.
               a_sh_d  = a;
               bn_sh_d = ~b;
               res_d   = '0;
               carry_d = 1'b1;
               cnt_d   = '0;
               sa_d    = a[N-1];
               sb_d    = b[N-1];
               state_d = S_RUN;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            a_sh_d  = a_sh_q >> K;
            bn_sh_d = bn_sh_q >> K;
            res_d   = res_shifted;
            carry_d = chunk_sum[K];
            cnt_d   = cnt_q + CW'(1);
            if (last_chunk) begin
               d_d      = res_shifted;
               // Final carry out of a + ~b + 1 is the inverse of the borrow.
               borrow_d = ~chunk_sum[K];
               // Overflow only possible when operand signs differ; it shows
               // up as the result sign disagreeing with the minuend sign.
               ovf_d    = (sa_q ^ sb_q) & (res_shifted[N-1] ^ sa_q);
               cnt_d    = '0;
               state_d  = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         bn_sh_q  <= '0;
         res_q    <= '0;
         d_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         bn_sh_q  <= bn_sh_d;
         res_q    <= res_d;
         d_q      <= d_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   // Status decoded straight from the state register; no input feeds through.
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign d        = d_q;
   assign borrow   = borrow_q;
   assign overflow = ovf_q;

endmodule
